// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe
//   Two-stage pipelined unpacker for posit<WIDTH,EN>, feeding the posit adder's
//   alignment logic. Stage 1 captures the sign, magnitude and special-value
//   flags. Stage 2 extracts the regime, exponent and fraction, and registers
//   the sign, the signed scale (k*2^EN + e) and the hidden-bit mantissa.
//   Valid/ready on both sides. One decode per cycle. No path from in_* to out_*.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input posit valid
//   in_ready   block can accept an input this cycle
//   in_posit   packed posit word
//   out_valid  decoded result valid
//   out_ready  downstream accepts the result
//   out_sign   sign bit (0 for zero/NaR)
//   out_scale  signed scale, two's complement (0 for zero/NaR)
//   out_mant   mantissa, MSB = hidden 1, fraction left-aligned (0 for zero/NaR)
//   out_zero   input was 0
//   out_nar    input was NaR
module posit_decode_pipe #(
  parameter  int WIDTH = 32,
  parameter  int EN    = 3,
  localparam int SW    = $clog2(WIDTH-1) + EN + 2,
  localparam int MW    = WIDTH - EN - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_posit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [SW-1:0]    out_scale,
  output logic [MW-1:0]    out_mant,
  output logic             out_zero,
  output logic             out_nar
);

  // Goes high on the first clock after reset release. It holds off input
  // acceptance until that clock.
  logic up_q;

  logic             s1_valid;
  logic             s1_sign;
  logic             s1_zero;
  logic             s1_nar;
  logic [WIDTH-2:0] s1_abs;     // magnitude without its MSB (always 0 unless NaR)

  logic s1_load;
  logic s2_load;

  // Each stage advances when it is empty or its contents move on this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = up_q && (!s1_valid || s2_load);
  assign in_ready = s1_load;

  // The low WIDTH-1 bits of -p are the two's complement of the low bits of p.
  logic [WIDTH-2:0] abs_in;
  assign abs_in = in_posit[WIDTH-1] ? (~in_posit[WIDTH-2:0] + (WIDTH-1)'(1))
                                    : in_posit[WIDTH-2:0];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values. Data registers are reset too, because the outputs must
  // read as zero while the block is in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_q     <= 1'b0;
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_abs   <= '0;
    end else begin
      up_q <= 1'b1;
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_posit[WIDTH-1];
          s1_abs  <= abs_in;
          s1_zero <= (in_posit == '0);
          s1_nar  <= (in_posit == {1'b1, {(WIDTH-1){1'b0}}});
        end
      end
    end
  end

  // Stage-2 field extraction from the stage-1 magnitude.
  logic             regime_bit;
  logic             found;
  int               run;        // regime run length, 1..WIDTH-1
  int               k;
  logic [WIDTH-4:0] rest;       // bits after the terminator, left-aligned
  logic [EN-1:0]    exp_c;
  logic [MW-2:0]    frac_c;
  logic [SW-1:0]    scale_c;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    regime_bit = s1_abs[WIDTH-2];
    found      = 1'b0;
    run        = WIDTH - 1;
    for (int i = WIDTH-3; i >= 0; i--) begin
      if (!found && (s1_abs[i] != regime_bit)) begin
        run   = WIDTH - 2 - i;
        found = 1'b1;
      end
    end
    // The two top bits are always regime/terminator. Shifting the remainder
    // by run-1 drops the rest of the run and the terminator. A run that reaches
    // bit 0 leaves nothing, so the exponent and fraction become zero.
    rest            = s1_abs[WIDTH-4:0] << (run - 1);
    {exp_c, frac_c} = rest;
    k               = regime_bit ? (run - 1) : -run;
    scale_c         = SW'(k * (2 ** EN) + int'(exp_c));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_scale <= '0;
      out_mant  <= '0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_zero <= s1_zero;
        out_nar  <= s1_nar;
        if (s1_zero || s1_nar) begin
          out_sign  <= 1'b0;
          out_scale <= '0;
          out_mant  <= '0;
        end else begin
          out_sign  <= s1_sign;
          out_scale <= scale_c;
          out_mant  <= {1'b1, frac_c};
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Testbench for posit_decode_pipe (posit<32,3>). The reference model decodes
// a posit by treating it as a bit stream in a queue: consume the regime run,
// the terminator, the exponent bits and then the fraction bits.
module tb_posit_decode_pipe;

  localparam int WIDTH = 32;
  localparam int EN    = 3;
  localparam int SW    = 10;
  localparam int MW    = 27;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_posit  = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_sign;
  logic [SW-1:0]    out_scale;
  logic [MW-1:0]    out_mant;
  logic             out_zero;
  logic             out_nar;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] scale;
    logic [MW-1:0] mant;
    logic          zero;
    logic          nar;
  } res_t;

  always #5 clk = ~clk;

  posit_decode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_scale (out_scale),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_nar   (out_nar)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  function automatic res_t snap();
    return {out_sign, out_scale, out_mant, out_zero, out_nar};
  endfunction

  function automatic res_t mk(input logic s, input int scale, input logic [MW-1:0] m,
                              input logic z, input logic n);
    res_t r;
    r.sign  = s;
    r.scale = SW'(scale);
    r.mant  = m;
    r.zero  = z;
    r.nar   = n;
    return r;
  endfunction

  // Reference decode: walk the bits after the sign as a stream.
  function automatic res_t model(input logic [WIDTH-1:0] p);
    res_t             x;
    bit               q[$];
    bit               r;
    logic [WIDTH-1:0] a;
    int               n, e, k;
    logic [MW-2:0]    f;
    x = '0;
    if (p == 0) begin
      x.zero = 1'b1;
      return x;
    end
    if (p == 32'h8000_0000) begin
      x.nar = 1'b1;
      return x;
    end
    x.sign = p[WIDTH-1];
    a = p[WIDTH-1] ? -p : p;
    for (int i = WIDTH-2; i >= 0; i--) q.push_back(a[i]);
    r = q[0];
    n = 0;
    while (q.size() > 0 && q[0] == r) begin
      void'(q.pop_front());
      n++;
    end
    if (q.size() > 0) void'(q.pop_front());
    e = 0;
    for (int i = 0; i < EN; i++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
    f = '0;
    for (int i = MW-2; i >= 0; i--) f[i] = (q.size() > 0) ? q.pop_front() : 1'b0;
    k = r ? n - 1 : -n;
    x.scale = SW'(k * (2 ** EN) + e);
    x.mant  = {1'b1, f};
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] gen();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2, 3:    v = $urandom >> $urandom_range(0, 31);
      4:       v = ~($urandom >> $urandom_range(0, 31));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One clock cycle: drive at posedge+1, sample at posedge+2, then wait for the next posedge+1.
  task automatic step(input logic iv, input logic [WIDTH-1:0] ip, input logic ordy,
                      output logic acc, output logic ov, output logic emit, output res_t r);
    in_valid  = iv;
    in_posit  = ip;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    ov   = out_valid;
    emit = out_valid && ordy;
    r    = snap();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (snap() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", snap());
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_in_ready_early: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_latency();
    logic acc, ov, emit;
    res_t r;
    step(1'b1, 32'h4000_0000, 1'b1, acc, ov, emit, r);
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept: got %b expected 1", acc);
    end
    step(1'b0, '0, 1'b1, acc, ov, emit, r);
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle1_valid: got %b expected 0", ov);
    end
    step(1'b0, '0, 1'b1, acc, ov, emit, r);
    checks++;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL latency_cycle2_valid: got %b expected 1", ov);
    end
    checks++;
    if (r !== mk(1'b0, 0, 27'h400_0000, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL latency_result_40000000: got %h expected %h", r, mk(1'b0, 0, 27'h400_0000, 1'b0, 1'b0));
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] pin [6];
    res_t             exp [6];
    logic acc, ov, emit;
    res_t r;
    int   ni, no;
    pin[0] = 32'h4800_0000; exp[0] = mk(1'b0,    2, 27'h400_0000, 1'b0, 1'b0);
    pin[1] = 32'hC000_0000; exp[1] = mk(1'b1,    0, 27'h400_0000, 1'b0, 1'b0);
    pin[2] = 32'h0000_0001; exp[2] = mk(1'b0, -240, 27'h400_0000, 1'b0, 1'b0);
    pin[3] = 32'h7FFF_FFFF; exp[3] = mk(1'b0,  240, 27'h400_0000, 1'b0, 1'b0);
    pin[4] = 32'h0000_0000; exp[4] = mk(1'b0,    0, 27'h0,        1'b1, 1'b0);
    pin[5] = 32'h8000_0000; exp[5] = mk(1'b0,    0, 27'h0,        1'b0, 1'b1);
    ni = 0;
    no = 0;
    for (int c = 0; c < 20 && no < 6; c++) begin
      if (ni < 6) begin
        step(1'b1, pin[ni], 1'b1, acc, ov, emit, r);
        checks++;
        if (acc !== 1'b1) begin
          errors++;
          $display("FAIL directed_throughput[%0d]: got accept=%b expected 1", ni, acc);
        end
        if (acc) ni++;
      end else begin
        step(1'b0, '0, 1'b1, acc, ov, emit, r);
      end
      if (emit) begin
        checks++;
        if (r !== exp[no]) begin
          errors++;
          $display("FAIL directed_result[%0d] in=%h: got %h expected %h", no, pin[no], r, exp[no]);
        end
        no++;
      end
    end
    checks++;
    if (no != 6) begin
      errors++;
      $display("FAIL directed_count: got %0d expected 6", no);
    end
  endtask

  task automatic test_back_pressure();
    logic [WIDTH-1:0] items [4];
    logic acc, ov, emit;
    res_t r;
    int   nacc, nout;
    for (int i = 0; i < 4; i++) items[i] = $urandom | 32'h0000_0100;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, items[nacc < 4 ? nacc : 3], 1'b0, acc, ov, emit, r);
      if (acc) nacc++;
      if (c >= 2) begin
        checks++;
        if (acc !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready_low[%0d]: got accept=%b expected 0", c, acc);
        end
        checks++;
        if (ov !== 1'b1 || r !== model(items[0])) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got valid=%b %h expected valid=1 %h", c, ov, r, model(items[0]));
        end
      end
    end
    checks++;
    if (nacc != 2) begin
      errors++;
      $display("FAIL bp_accepts: got %0d expected 2", nacc);
    end
    nout = 0;
    for (int c = 0; c < 12; c++) begin
      if (nacc < 4) step(1'b1, items[nacc], 1'b1, acc, ov, emit, r);
      else          step(1'b0, '0, 1'b1, acc, ov, emit, r);
      if (acc) nacc++;
      if (emit) begin
        checks++;
        if (nout >= 4) begin
          errors++;
          $display("FAIL bp_duplicate: got extra output %h expected none", r);
        end else if (r !== model(items[nout])) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h expected %h", nout, r, model(items[nout]));
        end
        nout++;
      end
    end
    checks++;
    if (nout != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d expected 4", nout);
    end
  endtask

  task automatic test_random();
    res_t             sb[$];
    res_t             prev_r, want;
    logic             prev_stall;
    logic             acc, ov, emit, iv, ordy;
    logic [WIDTH-1:0] p;
    res_t             r;
    prev_stall = 1'b0;
    prev_r     = '0;
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      p    = gen();
      step(iv, p, ordy, acc, ov, emit, r);
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || r !== prev_r) begin
          errors++;
          $display("FAIL rand_hold[%0d]: got valid=%b %h expected valid=1 %h", c, ov, r, prev_r);
        end
      end
      if (emit) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected[%0d]: got %h expected no output", c, r);
        end else begin
          want = sb.pop_front();
          if (r !== want) begin
            errors++;
            $display("FAIL rand_result[%0d]: got %h expected %h", c, r, want);
          end
        end
      end
      if (acc) sb.push_back(model(p));
      prev_stall = ov && !ordy;
      prev_r     = r;
    end
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      step(1'b0, '0, 1'b1, acc, ov, emit, r);
      if (emit) begin
        want = sb.pop_front();
        checks++;
        if (r !== want) begin
          errors++;
          $display("FAIL drain_result[%0d]: got %h expected %h", c, r, want);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, ov, emit;
    res_t r;
    step(1'b1, 32'h4800_0000, 1'b0, acc, ov, emit, r);
    step(1'b1, 32'h5000_0000, 1'b0, acc, ov, emit, r);
    in_valid = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midflight_full: got %b expected 1", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || snap() !== res_t'(0)) begin
      errors++;
      $display("FAIL midflight_reset: got valid=%b %h expected valid=0 0", out_valid, snap());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, 1'b1, acc, ov, emit, r);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL midflight_stale[%0d]: got valid=%b expected 0", c, ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_pressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
